// File: rtl/match_event_logger_pkg.sv
// match_event_logger_pkg: shared defaults and pointer-width helper
package match_event_logger_pkg;
   localparam int TS_W_DEF  = 8;
   localparam int CNT_W_DEF = 8;
   localparam int DEPTH_DEF = 4;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/match_event_logger_if.sv
// match_event_logger_if: valid/ready event read port carrying a timestamp
interface match_event_logger_if #(parameter int TS_W = 8);
   logic            valid;
   logic            ready;
   logic [TS_W-1:0] timestamp;
   modport master (output valid, output timestamp, input ready);
   modport slave  (input valid, input timestamp, output ready);
endinterface

// File: rtl/match_event_logger_event_fifo.sv
// event_fifo: DEPTH x W synchronous FIFO with an extra-MSB pointer scheme
module event_fifo
   import match_event_logger_pkg::*;
#(
   parameter int W     = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] data_in,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [W-1:0]  mem [DEPTH];
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];
   // pointer update; callers only push with space and only pop when non-empty
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end
   // storage needs no reset: entries are only visible once written
   always_ff @(posedge clock) begin
      if (push && !clear) mem[wr_ptr[AW-1:0]] <= data_in;
   end
endmodule

// File: rtl/match_event_logger.sv
// match_event_logger: timestamps, counts and queues detector match pulses
module match_event_logger
   import match_event_logger_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             match_in,
   output logic [CNT_W-1:0] total_count,
   output logic             overflow,
   match_event_logger_if.master ev
);
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] head;
   logic            full, empty, hit, pop, push;
   assign hit  = enable && match_in;
   assign pop  = !empty && ev.ready && !clear;
   // a simultaneous pop frees the slot, so a full FIFO still accepts the push
   assign push = hit && (!full || pop) && !clear;
   assign ev.valid     = !empty;
   assign ev.timestamp = empty ? '0 : head;
   event_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .push    (push),
      .pop     (pop),
      .data_in (ts),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );
   // free-running stamp, saturating match count and sticky drop flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ts          <= '0;
         total_count <= '0;
         overflow    <= 1'b0;
      end else if (clear) begin
         ts          <= '0;
         total_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (enable) ts <= ts + TS_W'(1);
         if (hit && total_count != '1) total_count <= total_count + CNT_W'(1);
         if (hit && !push) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_match_event_logger.sv
// tb_match_event_logger: randomized and directed checks against a queue model
module tb_match_event_logger;
   localparam int DEPTH = 4;
   localparam int CMAX  = 255;
   logic clock = 0, reset = 0, enable = 0, clear = 0, match_in = 0;
   logic [7:0] total_count;
   logic       overflow;
   int checks = 0, errors = 0;
   bit started = 0;
   int m_ts = 0, m_cnt = 0;
   bit m_ovf = 0;
   int q[$];

   match_event_logger_if #(.TS_W(8)) ev ();

   match_event_logger #(.TS_W(8), .CNT_W(8), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .clear       (clear),
      .match_in    (match_in),
      .total_count (total_count),
      .overflow    (overflow),
      .ev          (ev)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // reference model: a plain queue of stamps plus counters
   always @(posedge clock or negedge reset) begin
      if (!reset || clear) begin
         m_ts = 0; m_cnt = 0; m_ovf = 0; q.delete();
      end else begin
         if (q.size() > 0 && ev.ready) void'(q.pop_front());
         if (enable && match_in) begin
            if (m_cnt < CMAX) m_cnt++;
            if (q.size() < DEPTH) q.push_back(m_ts);
            else m_ovf = 1;
         end
         if (enable) m_ts = (m_ts + 1) % 256;
      end
   end

   // every cycle, DUT outputs must equal the model
   always @(negedge clock) begin
      if (started) begin
         chk("cyc_valid", int'(ev.valid), q.size() > 0);
         chk("cyc_stamp", int'(ev.timestamp), q.size() > 0 ? q[0] : 0);
         chk("cyc_count", int'(total_count), m_cnt);
         chk("cyc_ovf", int'(overflow), int'(m_ovf));
         chk("cyc_ts", int'(dut.ts), m_ts);
      end
   end

   initial begin
      int exp_a[4];
      int saved;
      ev.ready = 0;
      started = 1;
      repeat (3) tick();
      chk("rst_valid", int'(ev.valid), 0);
      chk("rst_stamp", int'(ev.timestamp), 0);
      chk("rst_count", int'(total_count), 0);
      chk("rst_ovf", int'(overflow), 0);
      reset = 1;
      enable = 1;
      // basic latency: single match at ts=5
      while (m_ts != 5) tick();
      match_in = 1;
      tick();
      match_in = 0;
      chk("lat_valid", int'(ev.valid), 1);
      chk("lat_stamp", int'(ev.timestamp), 5);
      chk("lat_count", int'(total_count), 1);
      ev.ready = 1;
      tick();
      chk("lat_drained", int'(ev.valid), 0);
      ev.ready = 0;
      // fill and overflow: matches at ts=1..5
      clear = 1; tick(); clear = 0;
      tick();
      match_in = 1;
      repeat (5) tick();
      match_in = 0;
      chk("fill_head", int'(ev.timestamp), 1);
      chk("fill_ovf", int'(overflow), 1);
      chk("fill_count", int'(total_count), 5);
      exp_a = '{1, 2, 3, 4};
      ev.ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("fill_drain", int'(ev.timestamp), exp_a[i]);
         tick();
      end
      chk("fill_empty", int'(ev.valid), 0);
      ev.ready = 0;
      // full FIFO, push and pop in the same cycle
      clear = 1; tick(); clear = 0;
      while (m_ts != 10) tick();
      match_in = 1;
      repeat (4) tick();
      match_in = 0;
      while (m_ts != 20) tick();
      match_in = 1; ev.ready = 1;
      tick();
      match_in = 0;
      chk("fp_ovf", int'(overflow), 0);
      exp_a = '{11, 12, 13, 20};
      for (int i = 0; i < 4; i++) begin
         chk("fp_drain", int'(ev.timestamp), exp_a[i]);
         tick();
      end
      chk("fp_empty", int'(ev.valid), 0);
      // timestamp wrap and count saturation
      clear = 1; tick(); clear = 0;
      while (m_ts != 255) tick();
      match_in = 1;
      tick();
      chk("wrap_255", int'(ev.timestamp), 255);
      tick();
      chk("wrap_0", int'(ev.timestamp), 0);
      repeat (300) tick();
      match_in = 0;
      chk("sat_count", int'(total_count), 255);
      tick(); tick();
      // enable gating with match held high
      saved = m_ts;
      enable = 0; match_in = 1;
      repeat (10) tick();
      chk("gate_ts", int'(dut.ts), saved);
      chk("gate_count", int'(total_count), 255);
      chk("gate_valid", int'(ev.valid), 0);
      enable = 1; match_in = 0;
      // clear wins over a simultaneous match
      clear = 1; tick(); clear = 0;
      ev.ready = 0;
      match_in = 1;
      repeat (2) tick();
      chk("cq_valid", int'(ev.valid), 1);
      clear = 1;
      tick();
      clear = 0; match_in = 0;
      chk("clr_valid", int'(ev.valid), 0);
      chk("clr_count", int'(total_count), 0);
      chk("clr_ovf", int'(overflow), 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         enable   = ($urandom_range(0, 9) != 0);
         match_in = $urandom_range(0, 1);
         ev.ready = ($urandom_range(0, 2) == 0);
         clear    = ($urandom_range(0, 199) == 0);
         tick();
      end
      clear = 0; enable = 1; ev.ready = 0; match_in = 1;
      repeat (6) tick();
      match_in = 0;
      // asynchronous reset mid-cycle
      @(posedge clock);
      #3 reset = 0;
      #1;
      chk("arst_valid", int'(ev.valid), 0);
      chk("arst_stamp", int'(ev.timestamp), 0);
      chk("arst_count", int'(total_count), 0);
      chk("arst_ovf", int'(overflow), 0);
      tick();
      reset = 1;
      match_in = 1;
      tick();
      match_in = 0;
      chk("post_rst_stamp", int'(ev.timestamp), 0);
      chk("post_rst_count", int'(total_count), 1);
      tick();
      started = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial sequence detector's one-cycle `output_indicator` pulses. Each pulse is counted, stamped with a free-running cycle timestamp and queued in a small FIFO. A host drains the FIFO over a valid/ready handshake. Lost events are flagged by a sticky overflow bit.

## Interface
Parameters:
- `TS_W`, 8: timestamp width in bits; the timestamp wraps modulo 2^TS_W.
- `CNT_W`, 8: total-match counter width; the counter saturates.
- `DEPTH`, 4: number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `enable`  in  1  when 0, the timestamp freezes and `match_in` is ignored; reads still proceed.
- `clear`  in  1  synchronous soft reset, same effect as `reset`, at the next edge.
- `match_in`  in  1  detector pulse; a 1 means one match in this cycle.
- `ev_valid`  out  1  FIFO head holds an entry.
- `ev_ready`  in  1  host accepts the head entry this cycle.
- `ev_timestamp`  out  TS_W  head entry timestamp; 0 when `ev_valid`=0.
- `total_count`  out  CNT_W  matches seen since reset or clear; saturates at 2^CNT_W-1.
- `overflow`  out  1  sticky; set when a match was dropped because the FIFO was full.

## Operation
- Timestamp counter `ts`:
  - +1 every cycle while `enable`=1, wrapping from 2^TS_W-1 to 0.
  - Holds its value while `enable`=0.
- Match accepted in a cycle when `match_in`=1 and `enable`=1:
  - `total_count` +1, unless already at its maximum.
  - Push the current `ts` value (pre-increment) into the FIFO if there is space.
  - Otherwise drop the entry and set `overflow`=1.
- Pop happens when `ev_valid`=1 and `ev_ready`=1. `ev_ready` while empty has no effect.
- Simultaneous push and pop while full:
  - The pop frees a slot, so the push is accepted.
  - No drop occurs, `overflow` is unchanged and occupancy stays at DEPTH.
- Simultaneous push and pop while empty: the push is accepted and nothing is popped; the entry becomes visible next cycle.
- FIFO pointers are log2(DEPTH)+1 bits wide.
  - Full: the pointer MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.
  - Pointers wrap naturally.
- `clear`:
  - Zeroes `ts`, `total_count`, `overflow` and both FIFO pointers.
  - Takes priority over a push, a pop or `enable` in the same cycle.
- `overflow` is cleared only by `reset` or `clear`.
- Reset values: `ev_valid`=0, `ev_timestamp`=0, `total_count`=0, `overflow`=0, and internal `ts`=0.

## Timing
- All outputs are registered or decoded directly from registered state. There are no combinational paths from inputs to outputs.
- Match at edge n with an empty FIFO: `ev_valid`=1 and `ev_timestamp` equal to the cycle-n `ts` are visible after edge n+1 (1-cycle latency).
- A pop at edge n exposes the next entry, or `ev_valid`=0, after edge n.
- `total_count` and `overflow` update at the same edge as the push decision.
- Back-to-back matches are accepted on consecutive cycles, one per cycle.
- `reset` asserted mid-transfer discards all queued entries asynchronously. After `reset` is released, the first edge behaves as the first edge after power-up.

## Structure
- Shared package holds:
  - the default constants `TS_W_DEF`, `CNT_W_DEF` and `DEPTH_DEF`;
  - a `ptr_w` function computing clog2(DEPTH)+1.
- Sub-module `event_fifo`: a DEPTH x TS_W synchronous FIFO with push, pop, full, empty and head data, plus a clear input.
- The top level holds the timestamp counter, the saturating counter, the overflow flag and the push/drop decision.

## Test plan
- Basic latency:
  - Stimulus: after reset, `enable`=1 and `ev_ready`=0; single `match_in` pulse at ts=5.
  - Required: next cycle `ev_valid`=1, `ev_timestamp`=5, `total_count`=1.
- Fill and overflow:
  - Stimulus: `ev_ready`=0, DEPTH=4; 5 matches at ts=1,2,3,4,5.
  - Required: `ev_timestamp` reads 1; after draining, the entries are 1,2,3,4 in order; `overflow`=1; `total_count`=5.
- Full push and pop in one cycle:
  - Stimulus: FIFO full with entries 10,11,12,13; `ev_ready`=1 together with a match at ts=20.
  - Required: `overflow` stays 0; the drained sequence is 11,12,13,20.
- Wrap and saturation:
  - Stimulus: TS_W=8, CNT_W=8, `ev_ready`=1; a match at ts=255 and another at ts=0; then 300 more matches.
  - Required: the two stamps read 255 then 0; `total_count` holds at 255.
- Enable gating:
  - Stimulus: `enable`=0 for 10 cycles with `match_in` held at 1.
  - Required: `ts` frozen, no push, `total_count` unchanged.
- Clear versus match, and reset:
  - Stimulus 1: `clear`=1 in the same cycle as a match, with 2 entries queued.
  - Required 1: next cycle `ev_valid`=0, `total_count`=0, `overflow`=0.
  - Stimulus 2: `reset`=0 asserted mid-cycle.
  - Required 2: all outputs are 0 immediately, without waiting for a clock edge.
